// File: rtl/nvdla_csb_sequencer_if.sv
// CSB sequencer bus bundle: host command, NVDLA request/response and read-data stream.
// Member suffixes are from the sequencer's point of view (slave modport).
interface nvdla_csb_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdat_i;
    logic                  cmd_write_i;

    logic                  csb_valid_o;
    logic                  csb_ready_i;
    logic [ADDR_WIDTH-1:0] csb_addr_o;
    logic [DATA_WIDTH-1:0] csb_wdat_o;
    logic                  csb_write_o;
    logic                  csb_nposted_o;

    logic                  rsp_valid_i;
    logic [DATA_WIDTH-1:0] rsp_data_i;
    logic                  rsp_wr_complete_i;

    logic                  rdata_valid_o;
    logic                  rdata_ready_i;
    logic [DATA_WIDTH-1:0] rdata_o;

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_wdat_i, cmd_write_i,
        input  csb_ready_i, rsp_valid_i, rsp_data_i, rsp_wr_complete_i, rdata_ready_i,
        output cmd_ready_o, csb_valid_o, csb_addr_o, csb_wdat_o, csb_write_o, csb_nposted_o,
        output rdata_valid_o, rdata_o
    );

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_wdat_i, cmd_write_i,
        output csb_ready_i, rsp_valid_i, rsp_data_i, rsp_wr_complete_i, rdata_ready_i,
        input  cmd_ready_o, csb_valid_o, csb_addr_o, csb_wdat_o, csb_write_o, csb_nposted_o,
        input  rdata_valid_o, rdata_o
    );
endinterface

// File: rtl/nvdla_csb_sequencer.sv
// Queues CSB register commands, issues them to NVDLA, tracks in-flight requests and buffers read data.
// Optional macro NVDLA_CSB_SEQ_POSTED_WR_EN: writes are posted and complete on the CSB handshake.
module nvdla_csb_sequencer #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    nvdla_csb_sequencer_if.slave                 bus,
    output logic [15:0]                          wr_done_cnt_o,
    output logic [15:0]                          rd_done_cnt_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 busy_o,
    output logic                                 err_o
);
    localparam int unsigned CPW = $clog2(FIFO_DEPTH);
    localparam int unsigned CCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdat;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_e;

    state_e                state_q, state_d;
    cmd_t                  cmd_mem_q [FIFO_DEPTH];
    logic [CPW-1:0]        cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [CCW-1:0]        cmd_cnt_q, cmd_cnt_d;
    logic [DATA_WIDTH-1:0] rd_mem_q [MAX_OUTSTANDING];
    logic [RPW-1:0]        rdf_wptr_q, rdf_wptr_d, rdf_rptr_q, rdf_rptr_d;
    logic [OW-1:0]         rdf_cnt_q, rdf_cnt_d;
    logic [OW-1:0]         outst_q, outst_d, rd_infl_q, rd_infl_d;
    logic [15:0]           wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic                  err_q, err_d, busy_q, busy_d, cmd_ready_q, cmd_ready_d;

    cmd_t          head, head_next;
    logic          cmd_push, cmd_pop, issue_rd, issue_np, posted_wr_hs;
    logic          rsp_rd_ok, rsp_wr_ok, counting, rdf_push, rdf_pop, elig;
    logic [CCW-1:0] cmd_avail;
    logic [OW:0]    rd_budget;

    function automatic logic [RPW-1:0] rdf_inc(input logic [RPW-1:0] p);
        return (p == RPW'(MAX_OUTSTANDING - 1)) ? '0 : p + RPW'(1);
    endfunction

    // Next-state for FIFOs, counters and the issue FSM
    always_comb begin
        head         = cmd_mem_q[cmd_rptr_q];
        cmd_push     = bus.cmd_valid_i && cmd_ready_q && !clear_i;
        cmd_pop      = (state_q == REQ) && bus.csb_ready_i;
        issue_rd     = cmd_pop && !head.write;
`ifdef NVDLA_CSB_SEQ_POSTED_WR_EN
        issue_np     = issue_rd;
        posted_wr_hs = cmd_pop && head.write;
        rsp_wr_ok    = 1'b0;
`else
        issue_np     = cmd_pop;
        posted_wr_hs = 1'b0;
        rsp_wr_ok    = bus.rsp_wr_complete_i && (outst_q != rd_infl_q);
`endif
        rsp_rd_ok = bus.rsp_valid_i && (rd_infl_q != '0);
        counting  = (state_q != FLUSH) && !clear_i;
        rdf_push  = rsp_rd_ok && counting;
        rdf_pop   = (rdf_cnt_q != '0) && bus.rdata_ready_i;

        outst_d   = outst_q + OW'(issue_np) - OW'(rsp_rd_ok) - OW'(rsp_wr_ok);
        rd_infl_d = rd_infl_q + OW'(issue_rd) - OW'(rsp_rd_ok);

        cmd_wptr_d = cmd_wptr_q + CPW'(cmd_push);
        cmd_rptr_d = cmd_rptr_q + CPW'(cmd_pop);
        cmd_cnt_d  = cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
        rdf_wptr_d = rdf_push ? rdf_inc(rdf_wptr_q) : rdf_wptr_q;
        rdf_rptr_d = rdf_pop ? rdf_inc(rdf_rptr_q) : rdf_rptr_q;
        rdf_cnt_d  = rdf_cnt_q + OW'(rdf_push) - OW'(rdf_pop);

        wr_done_d = wr_done_q + 16'((rsp_wr_ok || posted_wr_hs) && counting);
        rd_done_d = rd_done_q + 16'(rdf_push);
        err_d     = err_q || (bus.rsp_valid_i && !rsp_rd_ok) || (bus.rsp_wr_complete_i && !rsp_wr_ok);

        // A same-cycle push is deliberately not visible here: no FIFO bypass
        cmd_avail = cmd_cnt_q - CCW'(cmd_pop);
        head_next = cmd_mem_q[cmd_rptr_d];
        rd_budget = (OW+1)'(rd_infl_d) + (OW+1)'(rdf_cnt_d);
`ifdef NVDLA_CSB_SEQ_POSTED_WR_EN
        elig = head_next.write || ((outst_d < OW'(MAX_OUTSTANDING)) && (rd_budget < (OW+1)'(MAX_OUTSTANDING)));
`else
        elig = (outst_d < OW'(MAX_OUTSTANDING)) &&
               (head_next.write || (rd_budget < (OW+1)'(MAX_OUTSTANDING)));
`endif

        case (state_q)
            FLUSH:   state_d = (outst_d == '0) ? IDLE : FLUSH;
            REQ:     state_d = (!bus.csb_ready_i || ((cmd_avail != '0) && elig)) ? REQ : IDLE;
            default: state_d = ((cmd_avail != '0) && elig) ? REQ : IDLE;
        endcase

        if (clear_i) begin
            state_d    = (outst_d != '0) ? FLUSH : IDLE;
            cmd_wptr_d = '0;
            cmd_rptr_d = '0;
            cmd_cnt_d  = '0;
            rdf_wptr_d = '0;
            rdf_rptr_d = '0;
            rdf_cnt_d  = '0;
            wr_done_d  = '0;
            rd_done_d  = '0;
            err_d      = 1'b0;
        end

        cmd_ready_d = (cmd_cnt_d != CCW'(FIFO_DEPTH)) && (state_d != FLUSH);
        busy_d      = (cmd_cnt_d != '0) || (rdf_cnt_d != '0) || (outst_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_wptr_q  <= '0;
            cmd_rptr_q  <= '0;
            cmd_cnt_q   <= '0;
            rdf_wptr_q  <= '0;
            rdf_rptr_q  <= '0;
            rdf_cnt_q   <= '0;
            outst_q     <= '0;
            rd_infl_q   <= '0;
            wr_done_q   <= '0;
            rd_done_q   <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) cmd_mem_q[i] <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) rd_mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cmd_wptr_q  <= cmd_wptr_d;
            cmd_rptr_q  <= cmd_rptr_d;
            cmd_cnt_q   <= cmd_cnt_d;
            rdf_wptr_q  <= rdf_wptr_d;
            rdf_rptr_q  <= rdf_rptr_d;
            rdf_cnt_q   <= rdf_cnt_d;
            outst_q     <= outst_d;
            rd_infl_q   <= rd_infl_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            if (cmd_push) cmd_mem_q[cmd_wptr_q] <= '{write: bus.cmd_write_i, addr: bus.cmd_addr_i, wdat: bus.cmd_wdat_i};
            if (rdf_push) rd_mem_q[rdf_wptr_q] <= bus.rsp_data_i;
        end
    end

    assign bus.cmd_ready_o   = cmd_ready_q;
    assign bus.csb_valid_o   = (state_q == REQ);
    assign bus.csb_addr_o    = head.addr;
    assign bus.csb_wdat_o    = head.wdat;
    assign bus.csb_write_o   = head.write;
`ifdef NVDLA_CSB_SEQ_POSTED_WR_EN
    assign bus.csb_nposted_o = (state_q == REQ) && !head.write;
`else
    assign bus.csb_nposted_o = (state_q == REQ);
`endif
    assign bus.rdata_valid_o = (rdf_cnt_q != '0);
    assign bus.rdata_o       = rd_mem_q[rdf_rptr_q];
    assign wr_done_cnt_o     = wr_done_q;
    assign rd_done_cnt_o     = rd_done_q;
    assign outstanding_o     = outst_q;
    assign busy_o            = busy_q;
    assign err_o             = err_q;
endmodule
